// File: rtl/vball_sprite_sched.sv
// Per-scanline sprite scheduler: scans attribute RAM during hblank and streams line hits over valid/ready.
// Optional feature macro VBALL_SPR_TALL_EN: attribute bit 30 selects 32-row sprites instead of 16.
module vball_sprite_sched #(
   parameter int NUM_SPRITES  = 64,
   parameter int MAX_PER_LINE = 8,
   localparam int AW = $clog2(NUM_SPRITES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [8:0]    hcount,
   input  logic [8:0]    vcount,
   input  logic          flip,
   output logic [AW-1:0] spr_addr,
   input  logic [31:0]   spr_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_index,
   output logic [4:0]    out_row,
   output logic [21:0]   out_attr,
   output logic          overflow,
   output logic          late,
   output logic          busy
);

   localparam int IW = $clog2(MAX_PER_LINE);
   localparam int CW = $clog2(MAX_PER_LINE + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SPRITES - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_PER_LINE);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, EMIT = 2'd2} state_t;

   // Returns {hit, output_row}; the output row is already mirrored when the screen is flipped.
   function automatic logic [5:0] hit_row(input logic en, input logic tall, input logic [7:0] y,
                                          input logic [7:0] tl, input logic fl);
      logic [7:0] row;
      logic       hit;
      logic [4:0] orow;
      row = tl - y;
      if (tall) begin
         hit  = en && (row < 8'd32);
         orow = fl ? (5'd31 - row[4:0]) : row[4:0];
      end else begin
         hit  = en && (row < 8'd16);
         orow = fl ? (5'd15 - {1'b0, row[3:0]}) : {1'b0, row[3:0]};
      end
      return {hit, orow};
   endfunction

   state_t          state_r, state_nx_s;
   logic [AW-1:0]   addr_r, cmp_idx_r;
   logic            issue_r, cmp_valid_r, flip_r, ovf_r, overflow_r, late_r;
   logic [7:0]      tl_r;
   logic [CW-1:0]   cnt_r, head_r;
   logic [AW-1:0]   list_idx_r  [MAX_PER_LINE];
   logic [4:0]      list_row_r  [MAX_PER_LINE];
   logic [21:0]     list_attr_r [MAX_PER_LINE];

   logic [8:0]      tl_s;
   logic [7:0]      tl_cmp_s;
   logic [4:0]      orow_s;
   logic            start_s, scan_ok_s, tall_s, hit_s, full_s;
   logic            scan_last_s, list_empty_s, xfer_s, last_xfer_s;

`ifdef VBALL_SPR_TALL_EN
   assign tall_s = spr_data[30];
`else
   logic unused_tall_s;
   assign tall_s        = 1'b0;
   assign unused_tall_s = spr_data[30];
`endif

   assign tl_s         = (vcount == 9'd273) ? 9'd0 : (vcount + 9'd1);
   assign tl_cmp_s     = flip ? (8'd239 - tl_s[7:0]) : tl_s[7:0];
   assign start_s      = (hcount == 9'd240);
   assign scan_ok_s    = (tl_s < 9'd240);
   assign {hit_s, orow_s} = hit_row(cmp_valid_r && spr_data[31], tall_s, spr_data[7:0], tl_r, flip_r);
   assign full_s       = (cnt_r == FULL_CNT);
   assign scan_last_s  = cmp_valid_r && (cmp_idx_r == LAST_ADDR);
   assign list_empty_s = (cnt_r == {CW{1'b0}}) && !hit_s;
   // A restart in the same cycle wins over the handshake, so that transfer is not taken.
   assign xfer_s       = (state_r == EMIT) && out_ready && !start_s;
   assign last_xfer_s  = xfer_s && ((head_r + CW'(1)) == cnt_r);

   assign spr_addr  = addr_r;
   assign out_valid = (state_r == EMIT);
   assign busy      = (state_r != IDLE);
   assign out_index = list_idx_r[head_r[IW-1:0]];
   assign out_row   = list_row_r[head_r[IW-1:0]];
   assign out_attr  = list_attr_r[head_r[IW-1:0]];
   assign overflow  = overflow_r;
   assign late      = late_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nx_s = state_r;
      if (start_s) begin
         state_nx_s = scan_ok_s ? SCAN : IDLE;
      end else begin
         case (state_r)
            IDLE: state_nx_s = IDLE;
            SCAN: begin
               if (scan_last_s) begin
                  state_nx_s = list_empty_s ? IDLE : EMIT;
               end else begin
                  state_nx_s = SCAN;
               end
            end
            EMIT: begin
               if (last_xfer_s) begin
                  state_nx_s = IDLE;
               end else begin
                  state_nx_s = EMIT;
               end
            end
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // Scan address/compare pipeline, hit list and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r      <= {AW{1'b0}};
         cmp_idx_r   <= {AW{1'b0}};
         issue_r     <= 1'b0;
         cmp_valid_r <= 1'b0;
         flip_r      <= 1'b0;
         tl_r        <= 8'd0;
         ovf_r       <= 1'b0;
         overflow_r  <= 1'b0;
         late_r      <= 1'b0;
         cnt_r       <= {CW{1'b0}};
         head_r      <= {CW{1'b0}};
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            list_idx_r[i]  <= {AW{1'b0}};
            list_row_r[i]  <= 5'd0;
            list_attr_r[i] <= 22'd0;
         end
      end else begin
         late_r <= start_s && (state_r != IDLE) && (cnt_r != {CW{1'b0}});
         if (start_s) begin
            addr_r      <= {AW{1'b0}};
            issue_r     <= scan_ok_s;
            cmp_valid_r <= 1'b0;
            flip_r      <= flip;
            tl_r        <= tl_cmp_s;
            ovf_r       <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            head_r      <= {CW{1'b0}};
         end else begin
            cmp_valid_r <= issue_r;
            cmp_idx_r   <= addr_r;
            if (issue_r) begin
               if (addr_r == LAST_ADDR) begin
                  issue_r <= 1'b0;
                  addr_r  <= {AW{1'b0}};
               end else begin
                  addr_r  <= addr_r + AW'(1);
               end
            end
            if (hit_s) begin
               if (full_s) begin
                  ovf_r <= 1'b1;
               end else begin
                  list_idx_r[cnt_r[IW-1:0]]  <= cmp_idx_r;
                  list_row_r[cnt_r[IW-1:0]]  <= orow_s;
                  list_attr_r[cnt_r[IW-1:0]] <= spr_data[29:8];
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            if (scan_last_s) begin
               overflow_r <= ovf_r || (hit_s && full_s);
            end
            if (xfer_s) begin
               head_r <= head_r + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vball_sprite_sched.sv
// Self-checking bench for vball_sprite_sched: directed scenarios plus randomized lines against a list model.
module tb_vball_sprite_sched;

   logic        clk = 1'b0;
   logic        reset, flip, out_ready;
   logic [8:0]  hcount, vcount;
   logic [31:0] spr_data;
   logic [5:0]  spr_addr, out_index;
   logic        out_valid, overflow, late, busy;
   logic [4:0]  out_row;
   logic [21:0] out_attr;

   logic [31:0] mem [64];
   int          passed = 0;
   int          failed = 0;
   int          total  = 0;
   int          q_idx[$], q_row[$], q_attr[$];
   bit          ovf_model = 1'b0;
   int          fr;

   always #5 clk = ~clk;

   always @(posedge clk) spr_data <= mem[spr_addr];

   vball_sprite_sched #(.NUM_SPRITES(64), .MAX_PER_LINE(8)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .flip(flip),
      .spr_addr(spr_addr), .spr_data(spr_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_row(out_row), .out_attr(out_attr),
      .overflow(overflow), .late(late), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
   endtask

   // Reference: walk all sprites, keep the first 8 that cover the target line.
   task automatic build_model(input int tlc, input bit fl);
      logic [31:0] d;
      int row, h;
      q_idx.delete(); q_row.delete(); q_attr.delete();
      ovf_model = 1'b0;
      for (int i = 0; i < 64; i++) begin
         d = mem[i];
         row = (tlc - int'(d[7:0])) & 255;
         h = 16;
`ifdef VBALL_SPR_TALL_EN
         if (d[30]) h = 32;
`endif
         if (d[31] && row < h) begin
            if (q_idx.size() < 8) begin
               q_idx.push_back(i);
               q_row.push_back(fl ? (h - 1 - row) : row);
               q_attr.push_back(int'(d[29:8]));
            end else begin
               ovf_model = 1'b1;
            end
         end
      end
   endtask

   task automatic fill_random(input int tlc);
      for (int i = 0; i < 64; i++) begin
         mem[i] = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 22'($urandom),
                   8'((tlc - int'($urandom_range(0, 40))) & 255)};
      end
   endtask

   function automatic int tl_cmp_of(input int vc, input bit fl);
      int tl;
      tl = (vc == 273) ? 0 : vc + 1;
      return fl ? 239 - tl : tl;
   endfunction

   // Drives one hcount==240 event and follows the resulting scan/emit.
   task automatic run_line(input int vc, input bit fl, input int pct, input int hold,
                           input int abort_at, input bit exp_late, output int first_row);
      int tl, cyc, n;
      bit scan, rdy;
      tl = (vc == 273) ? 0 : vc + 1;
      scan = (tl < 240);
      if (scan) build_model(tl_cmp_of(vc, fl), fl);
      else begin
         q_idx.delete(); q_row.delete(); q_attr.delete();
      end
      n = q_idx.size();
      first_row = -1;
      hcount = 9'd240; vcount = vc[8:0]; flip = fl; out_ready = 1'b1;
      @(negedge clk);
      hcount = 9'd0; out_ready = 1'b0;
      check("late_t1", late, exp_late);
      check("busy_t1", busy, scan);
      if (scan) check("addr_t1", spr_addr, 0);
      @(negedge clk);
      check("late_t2", late, 0);
      repeat (63) @(negedge clk);
      check("valid_t65", out_valid, 0);
      if (scan) check("busy_t65", busy, 1);
      @(negedge clk);
      cyc = 66;
      check("overflow_t66", overflow, ovf_model);
      while (q_idx.size() > 0 && cyc < 2066) begin
         if (abort_at >= 0 && cyc >= 66 + abort_at) return;
         check("valid", out_valid, 1);
         check("index", out_index, q_idx[0]);
         check("row", out_row, q_row[0]);
         check("attr", out_attr, q_attr[0]);
         if (first_row < 0) first_row = int'(out_row);
         rdy = (cyc - 66 >= hold) && (int'($urandom_range(0, 99)) < pct);
         out_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) begin
            q_idx.pop_front(); q_row.pop_front(); q_attr.pop_front();
         end
      end
      check("drain_timeout", q_idx.size(), 0);
      out_ready = 1'b0;
      check("valid_end", out_valid, 0);
      check("busy_end", busy, 0);
      if (pct == 100 && hold == 0) check("drain_cycle", cyc, 66 + n);
   endtask

   initial begin
      reset = 1'b1; hcount = 9'd0; vcount = 9'd0; flip = 1'b0; out_ready = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_addr", spr_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_index", out_index, 0);
      check("rst_row", out_row, 0);
      check("rst_attr", out_attr, 0);
      check("rst_overflow", overflow, 0);
      check("rst_late", late, 0);
      check("rst_busy", busy, 0);

      // single hit on line 100
      mem[5] = {1'b1, 1'b0, 22'h2a5a5, 8'd100};
      run_line(99, 1'b0, 100, 0, -1, 1'b0, fr);
      check("single_row", fr, 0);

      // ten hits on line 50: first eight kept, overflow set, then cleared by an empty line
      clear_mem();
      for (int i = 0; i < 10; i++) mem[i] = {1'b1, 1'b0, 22'(i * 3 + 1), 8'd50};
      run_line(49, 1'b0, 100, 0, -1, 1'b0, fr);
      check("overflow_set", overflow, 1);
      clear_mem();
      run_line(50, 1'b0, 100, 0, -1, 1'b0, fr);
      check("overflow_clr", overflow, 0);

      // backpressure then late restart
      for (int i = 0; i < 5; i++) mem[i * 7 + 2] = {1'b1, 1'b0, 22'(i + 40), 8'(118 + i)};
      run_line(119, 1'b0, 100, 10, -1, 1'b0, fr);
      run_line(119, 1'b0, 0, 0, 3, 1'b0, fr);
      run_line(119, 1'b0, 100, 0, -1, 1'b1, fr);

      // flipped short sprite: row 3 mirrors to 12
      clear_mem();
      mem[7] = {1'b1, 1'b0, 22'h155, 8'd0};
      run_line(235, 1'b1, 100, 0, -1, 1'b0, fr);
      check("flip_row", fr, 12);
`ifdef VBALL_SPR_TALL_EN
      clear_mem();
      mem[9] = {1'b1, 1'b1, 22'h3ff, 8'd0};
      run_line(218, 1'b1, 100, 0, -1, 1'b0, fr);
      check("tall_flip_row", fr, 11);
`endif

      // Y wrap, no-scan line, last line wrapping to line 0
      clear_mem();
      mem[3] = {1'b1, 1'b0, 22'h12345, 8'd250};
      run_line(4, 1'b0, 100, 0, -1, 1'b0, fr);
      check("wrap_row", fr, 11);
      run_line(239, 1'b0, 100, 0, -1, 1'b0, fr);
      clear_mem();
      mem[2] = {1'b1, 1'b0, 22'h00abc, 8'd0};
      run_line(273, 1'b0, 100, 0, -1, 1'b0, fr);
      check("line0_row", fr, 0);

      // randomized lines
      for (int k = 0; k < 10; k++) begin
         int vc;
         bit fl;
         vc = int'($urandom_range(0, 238));
         fl = 1'($urandom_range(0, 1));
         fill_random(tl_cmp_of(vc, fl));
         run_line(vc, fl, int'($urandom_range(30, 100)), int'($urandom_range(0, 5)), -1, 1'b0, fr);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vball_sprite_sched.md
# vball_sprite_sched

Per-scanline sprite scheduler for the video pipeline. During horizontal blank it scans sprite attribute RAM for the next line, keeps up to `MAX_PER_LINE` sprites that intersect that line, and hands them one at a time to the sprite renderer over a valid/ready interface. It runs from the video timing generator's `hcount`/`vcount` and is the only master of the sprite RAM read port.

## Interface
- `NUM_SPRITES`, 64: attribute RAM entries scanned per line; must be a power of two.
- `MAX_PER_LINE`, 8: hit-list depth.
- `clk` in 1: pixel clock, the same clock as the timing generator.
- `reset` in 1: synchronous, active-high.
- `hcount` in 9: horizontal counter, 0..320.
- `vcount` in 9: vertical counter, 0..273.
- `flip` in 1: screen flip.
- `spr_addr` out log2(NUM_SPRITES): sprite RAM read address.
- `spr_data` in 32: read data, one-cycle latency. Fields:
  - `[31]` enable
  - `[30]` tall
  - `[29:8]` attr
  - `[7:0]` Y
- `out_valid` out 1: hit entry available.
- `out_ready` in 1: renderer accepts the entry.
- `out_index` out log2(NUM_SPRITES): sprite number.
- `out_row` out 5: row within the sprite, 0..31.
- `out_attr` out 22: `spr_data[29:8]` passed through.
- `overflow` out 1: last completed scan found more than `MAX_PER_LINE` hits.
- `late` out 1: one-cycle pulse when untransferred entries are discarded.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, SCAN and EMIT.
- **IDLE → SCAN** when `hcount==240`. The target line is `tl = (vcount==273) ? 0 : vcount+1`.
  - If `tl >= 240`, stay in IDLE.
  - If `flip`, use `tl' = 239 - tl` for the comparison.
- **SCAN**:
  - `spr_addr` steps 0..NUM_SPRITES-1, one entry per cycle.
  - Each returned word is compared one cycle after its address: `row = (tl - Y) mod 256`, 8-bit.
  - Hit condition: `enable && row < H`, where H is 16, or 32 when `tall` is set (see Configuration).
  - A hit appends {index, `row[4:0]`, attr} to the list, in ascending index order.
  - A hit found while the list is full is dropped and sets the internal `ovf` bit. The scan still covers all entries.
- **SCAN → EMIT** in the cycle after the last compare. `overflow` takes the value of `ovf` at that point. If the list is empty, go to IDLE instead.
- **EMIT**:
  - `out_valid=1` and the head entry is presented.
  - A transfer happens on `out_valid && out_ready`, then the next entry is presented.
  - Output fields stay stable while `out_valid && !out_ready`.
  - After the last transfer, go to IDLE.
- **Output row under flip**: `out_row = (H-1) - row`. Otherwise `out_row = row`.
- **`hcount==240` while in SCAN or EMIT**: the list is cleared, `late` pulses if any entries remained untransferred, and a new SCAN starts. Restart takes priority over a transfer in the same cycle; that transfer does not count.
- **Reset**: state IDLE, list empty, `ovf` and `overflow` cleared. Reset mid-scan or mid-emit abandons the line with no `late` pulse.

## Timing
- Reset values: `spr_addr=0`, `out_valid=0`, `out_index=0`, `out_row=0`, `out_attr=0`, `overflow=0`, `late=0`, `busy=0`.
- Cycle T is the cycle `hcount==240` is sampled.
  - T+1: state is SCAN, `busy=1`, `spr_addr=0`.
  - Address n is presented at T+1+n; its compare happens at T+2+n.
  - EMIT is entered at T+NUM_SPRITES+2, which is T+66 with defaults.
- The first `out_valid` rises at T+66. With `out_ready` held high, one entry transfers per cycle; 8 hits drain by T+73, inside the 80-cycle blank.
- `out_valid` deasserts the cycle after the final transfer.
- `late` is high for exactly the restart cycle + 1.

## Configuration
- `VBALL_SPR_TALL_EN`
  - Defined: bit 30 selects `H=32`. `row` is 5 bits; flip uses 31-row.
  - Undefined: `H=16` for all sprites, bit 30 is ignored, and `out_row[4]` is always 0.

## Test plan
- **Single hit**: entry 5 = {en=1, Y=100}, `vcount=99`, `hcount` reaches 240 → one transfer at T+66 with index 5, row 0. `busy` returns low at T+67.
- **Overflow**: 10 enabled entries with Y=50, line 50 → indices 0..7 are emitted in order, `overflow=1`. The next line with no hits clears `overflow`.
- **Backpressure**: `out_ready` low for 10 cycles after `out_valid` → fields hold, no entry is lost, order is preserved.
- **Late**: `out_ready` held low across the next `hcount==240` → `late` pulses once and the new scan starts at the following cycle.
- **Flip / tall**: `flip=1`, Y=0, `tl'` gives row 3 → `out_row=12`. With `VBALL_SPR_TALL_EN` and tall=1, row 20 → hit, `out_row=11`.
- **Wrap and bounds**: Y=250, line 5 → row 11, so a hit. At `vcount=239`, no scan starts and `busy` stays 0. At `vcount=273`, the scan targets line 0.
